// File: rtl/psum_accum_sfu_pkg.sv
// psum_accum_sfu_pkg: shared types and helpers for the psum accumulator.
// Holds the FSM state enum, pass-counter width and a lane-slice helper.
package psum_accum_sfu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam int PC_W = 4;

    // Low bit index of a lane inside a packed row.
    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/psum_accum_sfu_if.sv
// psum_accum_sfu_if: FIFO pop port and output SRAM write port.
// master: accumulator side; slave: FIFO / SRAM side.
interface psum_accum_sfu_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 4
);
    logic                     ofifo_valid;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     out_wr;
    logic [addr_w-1:0]        out_addr;
    logic [col*psum_bw-1:0]   out_data;

    modport master (
        input  ofifo_valid,
        input  ofifo_out,
        output ofifo_rd,
        output out_wr,
        output out_addr,
        output out_data
    );

    modport slave (
        output ofifo_valid,
        output ofifo_out,
        input  ofifo_rd,
        input  out_wr,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/psum_accum_sfu_bank.sv
// psum_bank: 2^depth_w x width register file, 1 write / 1 async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module psum_bank #(
    parameter int depth_w = 4,
    parameter int width   = 128
) (
    input  logic               clk,
    input  logic               we,
    input  logic [depth_w-1:0] waddr,
    input  logic [width-1:0]   wdata,
    input  logic [depth_w-1:0] raddr,
    output logic [width-1:0]   rdata
);
    logic [width-1:0] mem [0:(2**depth_w)-1];

    // No reset: pass 0 overwrites every row before it is read back.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/psum_accum_sfu.sv
// psum_accum_sfu: accumulates FIFO rows into a psum bank over several
// passes, then flushes finished rows to the output SRAM.
// Ports: clk, reset (sync, active-high), start/num_rows/num_passes
// command, bus (FIFO pop + SRAM write, master side), busy, done.
// Option: define PSUM_ACCUM_SFU_RELU_EN to clamp negative lanes to 0
// on flush; otherwise finished rows are written unchanged.
module psum_accum_sfu
    import psum_accum_sfu_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [addr_w:0]  num_rows,
    input  logic [PC_W-1:0]  num_passes,
    psum_accum_sfu_if.master bus,
    output logic             busy,
    output logic             done
);
    localparam int W = col * psum_bw;
    localparam logic [addr_w:0]   ONE_R = 1;
    localparam logic [PC_W-1:0]   ONE_P = 1;
    localparam logic [addr_w-1:0] ONE_A = 1;

    state_e state;
    state_e state_nx;

    logic [addr_w:0]   nr_q;
    logic [PC_W-1:0]   np_q;
    logic [addr_w-1:0] rp;
    logic [PC_W-1:0]   pc;

    logic              rd_q;
    logic              cap;
    logic              wr_q;
    logic [addr_w-1:0] addr_q;
    logic [W-1:0]      data_q;

    logic [W-1:0] bank_rd;
    logic [W-1:0] bank_wd;
    logic [W-1:0] sum_row;
    logic [W-1:0] flush_row;

    logic start_ok;
    logic zero_cnt;
    logic row_last;
    logic pass_last;
    logic last_cap;
    logic bank_we;
    logic issue;

    assign start_ok  = (state == S_IDLE) && start && !busy;
    assign zero_cnt  = (num_rows == '0) || (num_passes == '0);
    assign row_last  = ({1'b0, rp} == (nr_q - ONE_R));
    assign pass_last = (pc == (np_q - ONE_P));
    // cap marks the cycle in which ofifo_out holds the popped row.
    assign last_cap  = cap && row_last && pass_last;
    assign bank_we   = (state == S_ACCUM) && cap;
    assign bank_wd   = (pc == '0) ? bus.ofifo_out : sum_row;

    psum_bank #(
        .depth_w (addr_w),
        .width   (W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (rp),
        .wdata (bank_wd),
        .raddr (rp),
        .rdata (bank_rd)
    );

    // Lane-wise wrapping add of the stored psum and the new row.
    always_comb begin
        sum_row = '0;
        for (int i = 0; i < col; i++) begin
            sum_row[lane_lo(i, psum_bw) +: psum_bw] =
                bank_rd[lane_lo(i, psum_bw) +: psum_bw] +
                bus.ofifo_out[lane_lo(i, psum_bw) +: psum_bw];
        end
    end

`ifdef PSUM_ACCUM_SFU_RELU_EN
    always_comb begin
        flush_row = bank_rd;
        for (int i = 0; i < col; i++) begin
            if (bank_rd[lane_lo(i, psum_bw) + psum_bw - 1]) begin
                flush_row[lane_lo(i, psum_bw) +: psum_bw] = '0;
            end
        end
    end
`else
    assign flush_row = bank_rd;
`endif

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nx = zero_cnt ? S_DONE : S_ACCUM;
                    issue    = !zero_cnt && bus.ofifo_valid;
                end
            end
            S_ACCUM: begin
                // Never pop during the capture cycle, nor past the
                // final row of the final pass.
                issue = bus.ofifo_valid && !rd_q && !last_cap;
                if (last_cap) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (row_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            nr_q   <= '0;
            np_q   <= '0;
            rp     <= '0;
            pc     <= '0;
            rd_q   <= 1'b0;
            cap    <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            // Held through the done cycle so busy drops after done.
            busy  <= (state_nx != S_IDLE) || (state == S_DONE);
            done  <= (state == S_DONE);
            rd_q  <= issue;
            cap   <= rd_q;
            wr_q  <= (state == S_FLUSH);
            if (start_ok) begin
                nr_q <= num_rows;
                np_q <= num_passes;
                rp   <= '0;
                pc   <= '0;
            end
            if (bank_we) begin
                if (row_last) begin
                    rp <= '0;
                    pc <= pc + ONE_P;
                end else begin
                    rp <= rp + ONE_A;
                end
            end
            if (state == S_FLUSH) begin
                addr_q <= rp;
                data_q <= flush_row;
                rp     <= row_last ? '0 : rp + ONE_A;
            end
        end
    end

    assign bus.ofifo_rd = rd_q;
    assign bus.out_wr   = wr_q;
    assign bus.out_addr = addr_q;
    assign bus.out_data = data_q;
endmodule

// File: tb/tb_psum_accum_sfu.sv
// tb_psum_accum_sfu: directed self-checking bench for psum_accum_sfu.
// Models the FIFO, records SRAM writes, checks timing and data.
module tb_psum_accum_sfu;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 4;
    localparam int W   = COL * BW;

`ifdef PSUM_ACCUM_SFU_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_rows;
    logic [3:0]    num_passes;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int t;
    int rd_cnt = 0;
    int rd_viol = 0;
    int done_cnt = 0;

    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    wr_t          wq[$];

    psum_accum_sfu_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) bus();

    psum_accum_sfu #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_rows   (num_rows),
        .num_passes (num_passes),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO model and output monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ofifo_rd) begin
            rd_cnt++;
            if (!bus.ofifo_valid) rd_viol++;
            if (fq.size() > 0) bus.ofifo_out = fq.pop_front();
        end
        if (bus.out_wr) wq.push_back({bus.out_addr, bus.out_data});
        if (done) done_cnt++;
    end

    function automatic logic [W-1:0] mk_row(input int e, input int o);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++)
            r[i*BW +: BW] = (i % 2 == 0) ? BW'(e) : BW'(o);
        return r;
    endfunction

    function automatic int fx(input int v);
        return (RELU && v < 0) ? 0 : v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wq.delete();
        exp_q.delete();
        fq.delete();
        rd_cnt = 0;
        rd_viol = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(input int r, input int p);
        @(negedge clk);
        num_rows = (AW+1)'(r);
        num_passes = 4'(p);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        if (done) lat = cyc - t0;
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, W'(wq.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), W'(wq[i].a), W'(i));
                chk($sformatf("%s_data%0d", tag, i), wq[i].d, exp_q[i]);
            end
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rd"},   W'(bus.ofifo_rd), W'(0));
        chk({tag, "_wr"},   W'(bus.out_wr),   W'(0));
        chk({tag, "_addr"}, W'(bus.out_addr), W'(0));
        chk({tag, "_data"}, bus.out_data,     W'(0));
        chk({tag, "_busy"}, W'(busy),         W'(0));
        chk({tag, "_done"}, W'(done),         W'(0));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_rows = '0;
        num_passes = '0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out = '0;
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        reset = 1'b0;
        bus.ofifo_valid = 1'b1;

        // Single pass, R=4: lanes {r, -r, ...}.
        clr();
        for (int r = 0; r < 4; r++) begin
            fq.push_back(mk_row(r, -r));
            exp_q.push_back(mk_row(fx(r), fx(-r)));
        end
        do_start(4, 1);
        chk("t1_first_rd", W'(bus.ofifo_rd), W'(1));
        chk("t1_busy_up", W'(busy), W'(1));
        wait_done(100, t);
        chk("t1_done_lat", W'(t), W'(14));
        @(negedge clk);
        chk("t1_busy_down", W'(busy), W'(0));
        chk("t1_done_cnt", W'(done_cnt), W'(1));
        chk("t1_rd_cnt", W'(rd_cnt), W'(4));
        chk_writes("t1");

        // Three passes, R=2, lanes 5 -> 15.
        clr();
        repeat (6) fq.push_back(mk_row(5, 5));
        repeat (2) exp_q.push_back(mk_row(15, 15));
        do_start(2, 3);
        wait_done(100, t);
        chk("t2_done_lat", W'(t), W'(16));
        @(negedge clk);
        chk("t2_rd_cnt", W'(rd_cnt), W'(6));
        chk_writes("t2");

        // Overflow wrap: 0x7fff + 0x0001.
        clr();
        fq.push_back(mk_row(32767, 32767));
        fq.push_back(mk_row(1, 1));
        exp_q.push_back(mk_row(fx(-32768), fx(-32768)));
        do_start(1, 2);
        wait_done(100, t);
        chk("t3_done_lat", W'(t), W'(7));
        @(negedge clk);
        chk_writes("t3");

        // FIFO stall: valid low for 10 sampled cycles mid-pass.
        clr();
        for (int r = 0; r < 4; r++) begin
            fq.push_back(mk_row(r, -r));
            exp_q.push_back(mk_row(fx(r), fx(-r)));
        end
        do_start(4, 1);
        repeat (3) @(negedge clk);
        bus.ofifo_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.ofifo_valid = 1'b1;
        wait_done(100, t);
        chk("t4_done_lat", W'(t), W'(24));
        @(negedge clk);
        chk("t4_rd_viol", W'(rd_viol), W'(0));
        chk("t4_rd_cnt", W'(rd_cnt), W'(4));
        chk_writes("t4");

        // Reset in ACCUM after three captures.
        clr();
        for (int r = 0; r < 4; r++) fq.push_back(mk_row(r + 1, 9));
        do_start(4, 1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outs("t5_abort");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_done", W'(done_cnt), W'(0));
        chk("t5_no_wr", W'(wq.size()), W'(0));
        clr();
        fq.push_back(mk_row(-3, 7));
        exp_q.push_back(mk_row(fx(-3), 7));
        do_start(1, 1);
        wait_done(100, t);
        chk("t5_done_lat", W'(t), W'(5));
        @(negedge clk);
        chk_writes("t5");

        // Zero counts.
        clr();
        do_start(3, 0);
        wait_done(20, t);
        chk("t6_p0_lat", W'(t), W'(2));
        do_start(0, 2);
        wait_done(20, t);
        chk("t6_r0_lat", W'(t), W'(2));
        @(negedge clk);
        chk("t6_zero_rd", W'(rd_cnt), W'(0));
        chk("t6_zero_wr", W'(wq.size()), W'(0));
        chk("t6_zero_done", W'(done_cnt), W'(2));

        // Start pulses while busy are ignored.
        clr();
        fq.push_back(mk_row(2, -2));
        fq.push_back(mk_row(4, 4));
        fq.push_back(mk_row(4, 4));
        exp_q.push_back(mk_row(fx(2), fx(-2)));
        do_start(1, 1);
        num_rows = 5'd2;
        num_passes = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, t);
        chk("t7_done_lat", W'(t), W'(5));
        chk("t7_busy_at_done", W'(busy), W'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t7_done_cnt", W'(done_cnt), W'(1));
        chk("t7_busy_idle", W'(busy), W'(0));
        chk("t7_rd_cnt", W'(rd_cnt), W'(1));
        chk_writes("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_accum_sfu.md
# psum_accum_sfu

Special-function/accumulation stage directly downstream of the output FIFO. It pops one row of `col` partial sums at a time and accumulates each row into a local psum bank across a programmed number of passes (kernel/channel tiles). After the last pass it streams the finished rows, optionally ReLU'd, to the output SRAM write port.

## Interface
- `col`, default 8: lanes per row; must match the FIFO column count.
- `psum_bw`, default 16: signed two's-complement width of each psum lane.
- `addr_w`, default 4: bank depth is 2^addr_w rows.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `num_rows`  in  addr_w+1  rows per pass, legal range 0..2^addr_w; latched on `start`.
- `num_passes`  in  4  accumulation passes, 0..15; latched on `start`.
- `ofifo_valid`  in  1  FIFO has a full row available.
- `ofifo_out`  in  col*psum_bw  FIFO row data; lane i is bits [(i+1)*psum_bw-1 : i*psum_bw].
- `ofifo_rd`  out  1  one-cycle pop request to the FIFO.
- `out_wr`  out  1  output SRAM write strobe.
- `out_addr`  out  addr_w  output SRAM row address.
- `out_data`  out  col*psum_bw  finished row, using the same lane packing as `ofifo_out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, ACCUM, FLUSH and DONE.
- **IDLE**
  - `start` latches `num_rows` and `num_passes` and clears the row pointer `rp` and pass counter `pc`.
  - If either latched count is 0, go straight to DONE with no reads or writes. Otherwise go to ACCUM.
- **ACCUM**
  - Issue `ofifo_rd` for one cycle when `ofifo_valid`=1 and no read is in flight.
  - Read latency is one cycle: `ofifo_out` is captured in the cycle after `ofifo_rd`, and `ofifo_rd` is forced low in that capture cycle.
  - At most one read is in flight, so peak throughput is one row per 2 cycles.
  - On capture:
    - When `pc`=0: bank[rp] <= row (overwrite, so no bank clear is needed).
    - When `pc`>0: bank[rp] <= bank[rp] + row, lane-wise, signed, psum_bw bits, wrap on overflow (no saturation).
  - Then `rp` increments. When `rp` reaches num_rows-1 it wraps to 0 and `pc` increments.
  - After the capture of row num_rows-1 on pass num_passes-1, go to FLUSH with `rp`=0.
  - If `ofifo_valid` drops, the FSM waits in ACCUM with no timeout.
- **FLUSH**
  - Each cycle: `out_wr`=1, `out_addr`=rp, `out_data`=f(bank[rp]), `rp`++.
  - After the write of row num_rows-1, go to DONE.
  - f is ReLU or identity; see Configuration.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`=1.
- `ofifo_rd` is never asserted outside ACCUM.

## Timing
- **Reset**: state IDLE. `ofifo_rd`, `out_wr`, `out_addr`, `out_data`, `busy` and `done` are all 0. Counters are cleared. Bank contents are don't-care.
- **Reset mid-operation**: aborts on the next edge with no `done` pulse. Any read in flight is dropped, and that FIFO row is lost.
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.
- **Latency**: with `ofifo_valid` held high, `start` to first `ofifo_rd` is 1 cycle. Total time to the `done` pulse is 2·R·P + R + 2 cycles, with R=num_rows and P=num_passes.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `PSUM_ACCUM_SFU_RELU_EN` defined: in FLUSH, each lane is written as max(lane, 0). Negative lanes become 0; zero and positive lanes pass unchanged.
- Undefined: lanes pass through unchanged (identity), and no ReLU logic is synthesised.

## Structure
- The shared package holds:
  - the state enum (IDLE/ACCUM/FLUSH/DONE);
  - the pass-counter width constant (4);
  - a lane-slice helper function.
- One sub-module, `psum_bank`: a 2^addr_w × col*psum_bw register file with 1 read port, 1 write port and no reset.
- The FSM, counters and lane adders live in the top module.

## Test plan
- **Single pass, ReLU on**: col=8, R=4, P=1. Row r lanes = {r, −r, …}. Expect 4 writes at addr 0..3 with negative lanes = 0, then `done` at cycle 2·4+4+2=14.
- **Three passes**: R=2, every row lanes = 5. Expect `out_data` lanes = 15 at addr 0 and 1.
- **Overflow wrap**: psum_bw=16, P=2, lanes 0x7FFF then 0x0001. Expect 0x8000 with ReLU off, and 0 with `PSUM_ACCUM_SFU_RELU_EN`.
- **FIFO stall**: `ofifo_valid` dropped for 10 cycles mid-pass. Expect no `ofifo_rd` while it is low, identical results, and `done` delayed by exactly 10 cycles.
- **Reset mid-ACCUM**: after 3 captures. Expect all outputs 0 on the next cycle and no `done`. A following `start` with R=1, P=1 completes correctly.
- **Zero counts and re-start**: `num_passes`=0 gives a `done` pulse 1 cycle after the state leaves IDLE, with no `ofifo_rd` and no `out_wr`. A `start` pulsed while `busy`=1 is ignored.
